// File: rtl/imem_fetch_responder.sv
// -----------------------------------------------------------------------------
// imem_fetch_responder
//
// Instruction-memory responder for the fetch stage. Requests arrive over a
// valid/ready handshake with word addresses. The array is read in the accept
// cycle. The word then travels through a (LATENCY-1)-deep valid-tagged shift
// register into a show-ahead FIFO of DEPTH entries. A credit counter limits
// outstanding requests to DEPTH, so the FIFO can never overflow.
//
// Handshake semantics (both channels):
//   - A transfer happens at a rising edge where valid && ready are both 1.
//   - While rsp_valid && !rsp_ready, the response payload
//     (rsp_instr/rsp_addr/rsp_err) holds stable.
//
// Optional feature macro: IMEM_BOUNDS_CHECK_EN
//   defined   : a request with any req_addr bit above ADDR_WIDTH set returns
//               rsp_err=1 and a NOP (32'h00000013) without reading the array.
//   undefined : the upper address bits alias into the array; rsp_err is 0.
//
// Ports:
//   clk, reset            clock (rising edge), async active-high reset
//   req_valid/req_ready   request handshake; req_addr = PC[XLEN-1:2]
//   rsp_valid/rsp_ready   response handshake; rsp_instr, rsp_addr, rsp_err
//   flush                 drop everything outstanding (branch redirect)
//   ld_we/ld_addr/ld_data loader write port, independent of the handshake
// -----------------------------------------------------------------------------
module imem_fetch_responder #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2,
    parameter int DEPTH      = 4,
    parameter     INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [XLEN-3:0]       req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [XLEN-1:0]       rsp_instr,
    output logic [XLEN-3:0]       rsp_addr,
    output logic                  rsp_err,
    input  logic                  flush,
    input  logic                  ld_we,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [XLEN-1:0]       ld_data
);

    localparam int EW = 2 * XLEN - 1;              // {err, addr, instr}
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

    // ------------------------------------------------------------------
    // Instruction array (not reset)
    // ------------------------------------------------------------------
    logic [XLEN-1:0] mem [2**ADDR_WIDTH];

    // The loader write lands at the edge, so a same-cycle read sees the old word.
    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem[ld_addr] <= ld_data;
        end
    end

    // ------------------------------------------------------------------
    // Accept and array read
    // ------------------------------------------------------------------
    logic            accept;
    logic            pop;
    logic            rd_err;
    logic [XLEN-1:0] rd_data;
    logic [EW-1:0]   rd_entry;
    logic [CW-1:0]   out_q, out_d;

    assign req_ready = !flush && (out_q < CW'(DEPTH));
    assign accept    = req_valid && req_ready;

`ifdef IMEM_BOUNDS_CHECK_EN
    assign rd_err  = |req_addr[XLEN-3:ADDR_WIDTH];
    assign rd_data = rd_err ? NOP : mem[req_addr[ADDR_WIDTH-1:0]];
`else
    assign rd_err  = 1'b0;
    assign rd_data = mem[req_addr[ADDR_WIDTH-1:0]];
`endif

    assign rd_entry = {rd_err, req_addr, rd_data};

    // ------------------------------------------------------------------
    // Latency pipeline: LATENCY-1 valid-tagged stages feeding the FIFO
    // ------------------------------------------------------------------
    logic          push_vld;
    logic [EW-1:0] push_entry;

    generate
        if (LATENCY == 1) begin : g_no_pipe
            assign push_vld   = accept;
            assign push_entry = rd_entry;
        end else begin : g_pipe
            logic [LATENCY-2:0] vld_q;
            logic [EW-1:0]      ent_q [LATENCY-1];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    vld_q <= '0;
                    for (int i = 0; i < LATENCY - 1; i++) begin
                        ent_q[i] <= '0;
                    end
                end else if (flush) begin
                    vld_q <= '0;
                end else begin
                    vld_q[0] <= accept;
                    ent_q[0] <= rd_entry;
                    for (int i = 1; i < LATENCY - 1; i++) begin
                        vld_q[i] <= vld_q[i-1];
                        ent_q[i] <= ent_q[i-1];
                    end
                end
            end

            assign push_vld   = vld_q[LATENCY-2];
            assign push_entry = ent_q[LATENCY-2];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Show-ahead FIFO and outstanding-credit counter
    // ------------------------------------------------------------------
    logic [EW-1:0]  fifo_q [DEPTH];
    logic [PW-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // flush masks the response so nothing pops in the flush cycle.
    assign rsp_valid = !flush && (cnt_q != '0);
    assign pop       = rsp_valid && rsp_ready;

    always_comb begin
        out_d = out_q;
        cnt_d = cnt_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (flush) begin
            out_d = '0;
            cnt_d = '0;
            wr_d  = '0;
            rd_d  = '0;
        end else begin
            out_d = out_q + CW'(accept) - CW'(pop);
            cnt_d = cnt_q + CW'(push_vld) - CW'(pop);
            if (push_vld) wr_d = ptr_inc(wr_q);
            if (pop)      rd_d = ptr_inc(rd_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= '0;
            cnt_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
        end else begin
            out_q <= out_d;
            cnt_q <= cnt_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
        end
    end

    // The storage is cleared on reset so the outputs read as zero afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else if (!flush && push_vld) begin
            fifo_q[wr_q] <= push_entry;
        end
    end

    assign {rsp_err, rsp_addr, rsp_instr} = fifo_q[rd_q];

endmodule

// File: tb/tb_imem_fetch_responder.sv
module tb_imem_fetch_responder;
  localparam int XLEN  = 32;
  localparam int AW    = 8;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-3:0] req_addr;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_instr;
  logic [XLEN-3:0] rsp_addr;
  logic            rsp_err;
  logic            flush;
  logic            ld_we;
  logic [AW-1:0]   ld_addr;
  logic [XLEN-1:0] ld_data;

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  imem_fetch_responder #(
    .XLEN(XLEN), .ADDR_WIDTH(AW), .LATENCY(LAT), .DEPTH(DEPTH), .INIT_FILE("")
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
    .rsp_addr(rsp_addr), .rsp_err(rsp_err), .flush(flush),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  // reference model: transaction queue plus memory image
  typedef struct {
    logic [XLEN-1:0] instr;
    logic [XLEN-3:0] addr;
    logic            err;
    int              due;
  } rsp_t;

  rsp_t            exp_q[$];
  logic [XLEN-1:0] mem_m [2**AW];
  int              cyc;
  int              n_cmp;
  int              n_bad;

  typedef struct {
    logic            rv;
    logic [XLEN-3:0] addr;
    logic            rr;
    logic            e_ready;
    logic            e_valid;
    logic [XLEN-1:0] e_instr;
    logic [XLEN-3:0] e_addr;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_read(input logic [XLEN-3:0] a, output logic [XLEN-1:0] d, output logic e);
`ifdef IMEM_BOUNDS_CHECK_EN
    if (a[XLEN-3:AW] != '0) begin
      d = 32'h0000_0013;
      e = 1'b1;
    end else begin
      d = mem_m[a[AW-1:0]];
      e = 1'b0;
    end
`else
    d = mem_m[a[AW-1:0]];
    e = 1'b0;
`endif
  endfunction

  // compares DUT outputs to the model; called mid-cycle (negedge)
  task automatic check_model();
    logic e_ready, e_valid;
    e_ready = !flush && (exp_q.size() < DEPTH);
    e_valid = !flush && (exp_q.size() > 0) && (exp_q[0].due <= cyc);
    check("req_ready", {31'd0, req_ready}, {31'd0, e_ready});
    check("rsp_valid", {31'd0, rsp_valid}, {31'd0, e_valid});
    if (e_valid) begin
      check("rsp_instr", rsp_instr, exp_q[0].instr);
      check("rsp_addr", {2'b00, rsp_addr}, {2'b00, exp_q[0].addr});
      check("rsp_err", {31'd0, rsp_err}, {31'd0, exp_q[0].err});
    end
  endtask

  // crosses the next rising edge and updates the model from the applied inputs
  task automatic advance();
    logic            e_ready, e_valid, e;
    logic [XLEN-1:0] d;
    e_ready = !flush && (exp_q.size() < DEPTH);
    e_valid = !flush && (exp_q.size() > 0) && (exp_q[0].due <= cyc);
    model_read(req_addr, d, e);
    @(posedge clk);
    if (flush) begin
      exp_q.delete();
    end else begin
      if (e_valid && rsp_ready) void'(exp_q.pop_front());
      if (req_valid && e_ready) exp_q.push_back('{d, req_addr, e, cyc + LAT});
    end
    if (ld_we) mem_m[ld_addr] = ld_data;
    cyc++;
    #1;
  endtask

  task automatic cycle();
    #4;
    check_model();
    advance();
  endtask

  // waits a bounded number of cycles for the next response and checks it
  task automatic expect_rsp(input string name, input logic [XLEN-1:0] ei,
                            input logic [XLEN-3:0] ea, input logic ee);
    bit found = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 8 && !found; k++) begin
      #4;
      check_model();
      if (rsp_valid === 1'b1) begin
        found = 1'b1;
        check({name, "_instr"}, rsp_instr, ei);
        check({name, "_addr"}, {2'b00, rsp_addr}, {2'b00, ea});
        check({name, "_err"}, {31'd0, rsp_err}, {31'd0, ee});
      end
      advance();
    end
    if (!found) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no response within 8 cycles", name);
    end
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    ld_we     = 1'b0;
    flush     = 1'b0;
    rsp_ready = 1'b1;
    repeat (n) cycle();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    reset = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    rsp_ready = 1'b0;
    flush     = 1'b0;
    ld_we     = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;

    // vector table: back-to-back fetch of words 0..3 (LATENCY 2)
    vecs[0] = '{1'b1, 30'd0, 1'b1, 1'b1, 1'b0, 32'h0,  30'd0};
    vecs[1] = '{1'b1, 30'd1, 1'b1, 1'b1, 1'b0, 32'h0,  30'd0};
    vecs[2] = '{1'b1, 30'd2, 1'b1, 1'b1, 1'b1, 32'h11, 30'd0};
    vecs[3] = '{1'b1, 30'd3, 1'b1, 1'b1, 1'b1, 32'h22, 30'd1};
    vecs[4] = '{1'b0, 30'd0, 1'b1, 1'b1, 1'b1, 32'h33, 30'd2};
    vecs[5] = '{1'b0, 30'd0, 1'b1, 1'b1, 1'b1, 32'h44, 30'd3};
    vecs[6] = '{1'b0, 30'd0, 1'b1, 1'b1, 1'b0, 32'h0,  30'd0};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_rsp_instr", rsp_instr, 32'd0);
    check("reset_rsp_addr", {2'b00, rsp_addr}, 32'd0);
    check("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    reset = 1'b0;
    #4;
    check("ready_after_reset", {31'd0, req_ready}, 32'd1);
    advance();

    // program download
    for (int i = 0; i < 2**AW; i++) begin
      ld_we   = 1'b1;
      ld_addr = AW'(i);
      if (i < 4)       ld_data = 32'(i + 1) * 32'h11;
      else if (i == 7) ld_data = 32'h0000_AAAA;
      else             ld_data = $urandom;
      cycle();
    end
    idle(2);

    // table-driven back-to-back fetch
    for (int k = 0; k < 7; k++) begin
      req_valid = vecs[k].rv;
      req_addr  = vecs[k].addr;
      rsp_ready = vecs[k].rr;
      #4;
      check($sformatf("vec%0d_ready", k), {31'd0, req_ready}, {31'd0, vecs[k].e_ready});
      check($sformatf("vec%0d_valid", k), {31'd0, rsp_valid}, {31'd0, vecs[k].e_valid});
      if (vecs[k].e_valid) begin
        check($sformatf("vec%0d_instr", k), rsp_instr, vecs[k].e_instr);
        check($sformatf("vec%0d_addr", k), {2'b00, rsp_addr}, {2'b00, vecs[k].e_addr});
      end
      advance();
    end
    idle(2);

    // backpressure / full
    rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1;
      req_addr  = 30'(8 + i);
      #4;
      check_model();
      if (i >= 4) check("full_ready", {31'd0, req_ready}, 32'd0);
      advance();
    end
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #4;
      check_model();
      check("stall_instr", rsp_instr, mem_m[8]);
      check("stall_addr", {2'b00, rsp_addr}, 32'd8);
      advance();
    end
    rsp_ready = 1'b1;
    #4;
    check_model();
    check("ready_in_pop_cycle", {31'd0, req_ready}, 32'd0);
    advance();
    rsp_ready = 1'b0;
    #4;
    check_model();
    check("ready_after_pop", {31'd0, req_ready}, 32'd1);
    advance();
    idle(8);

    // flush with three outstanding
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1;
      req_addr  = 30'(20 + i);
      cycle();
    end
    req_valid = 1'b0;
    flush     = 1'b1;
    #4;
    check("flush_cycle_valid", {31'd0, rsp_valid}, 32'd0);
    check_model();
    advance();
    flush = 1'b0;
    #4;
    check("post_flush_ready", {31'd0, req_ready}, 32'd1);
    check_model();
    advance();
    idle(3);
    req_valid = 1'b1;
    req_addr  = 30'd5;
    cycle();
    req_valid = 1'b0;
    #4;
    check("flush_t1_valid", {31'd0, rsp_valid}, 32'd0);
    check_model();
    advance();
    #4;
    check("flush_t2_valid", {31'd0, rsp_valid}, 32'd1);
    check("flush_t2_instr", rsp_instr, mem_m[5]);
    check_model();
    advance();
    idle(3);

    // read-before-write on address 7
    req_valid = 1'b1;
    req_addr  = 30'd7;
    ld_we     = 1'b1;
    ld_addr   = 8'd7;
    ld_data   = 32'h0000_BBBB;
    cycle();
    ld_we = 1'b0;
    expect_rsp("rbw_old", 32'h0000_AAAA, 30'd7, 1'b0);
    req_valid = 1'b1;
    req_addr  = 30'd7;
    cycle();
    expect_rsp("rbw_new", 32'h0000_BBBB, 30'd7, 1'b0);
    idle(3);

    // upper address bits
    req_valid = 1'b1;
    req_addr  = 30'h100;
    cycle();
`ifdef IMEM_BOUNDS_CHECK_EN
    expect_rsp("oob", 32'h0000_0013, 30'h100, 1'b1);
`else
    expect_rsp("alias", 32'h0000_0011, 30'h100, 1'b0);
`endif
    req_valid = 1'b1;
    req_addr  = 30'h0FF;
    cycle();
    expect_rsp("top_word", mem_m[255], 30'h0FF, 1'b0);
    idle(3);

    // reset in the middle of operation
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr  = 30'd1;
    cycle();
    req_addr  = 30'd2;
    cycle();
    req_valid = 1'b0;
    cycle();
    cycle();
    #2;
    reset = 1'b1;
    #1;
    check("midreset_valid", {31'd0, rsp_valid}, 32'd0);
    check("midreset_instr", rsp_instr, 32'd0);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #4;
    check("midreset_ready", {31'd0, req_ready}, 32'd1);
    check_model();
    advance();
    idle(4);
    req_valid = 1'b1;
    req_addr  = 30'd1;
    cycle();
    expect_rsp("refetch", 32'h0000_0022, 30'd1, 1'b0);
    idle(2);

    // randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      req_valid = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 9) == 0) req_addr = 30'($urandom);
      else                           req_addr = 30'($urandom_range(0, 31));
      rsp_ready = ($urandom_range(0, 99) < 70);
      flush     = ($urandom_range(0, 99) < 3);
      ld_we     = ($urandom_range(0, 99) < 10);
      ld_addr   = 8'($urandom_range(0, 31));
      ld_data   = $urandom;
      cycle();
    end
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
